irq_priority_ctrl: RTL and testbench

- Interrupt controller for the RISC-V CPU.
- Captures rising edges on external interrupt sources into pending bits and applies a per-source enable register.
- Picks the highest-index eligible source, presents it to the core over a req/ack handshake, and tracks nested in-service levels until `eret`.
- Highest set bit wins, and the source index is delivered as a binary ID.

---
 rtl/irq_priority_ctrl.sv | 105 ++++++++++
 tb/tb_irq_priority_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller: rising-edge capture into pending bits, per-source enables,
// highest-index selection and a req/ack handshake with nested in-service tracking.
module irq_priority_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               en_we,
  input  logic [NUM_SRC-1:0] en_wdata,
  output logic               irq,
  output logic [ID_BITS-1:0] irq_id,
  input  logic               irq_ack,
  input  logic               eret,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service,
  output logic [NUM_SRC-1:0] enable
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t               state_q, state_d;
  logic [ID_BITS-1:0]   irq_id_q, irq_id_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   in_service_q, in_service_d;
  logic [NUM_SRC-1:0]   enable_q;
  logic [NUM_SRC-1:0]   src_d;

  logic [NUM_SRC-1:0]   edge_det, cand, id_onehot, is_onehot;
  logic [ID_BITS-1:0]   top, is_top;
  logic                 eligible, ack_fire, withdraw;

  // Highest set index of a vector; zero when empty (callers qualify with a non-zero test).
  function automatic logic [ID_BITS-1:0] top_index(input logic [NUM_SRC-1:0] v);
    top_index = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (v[i]) top_index = ID_BITS'(i);
  endfunction

  always_comb begin
    edge_det = src & ~src_d;
    cand     = pending_q & enable_q;
    top      = top_index(cand);
    is_top   = top_index(in_service_q);
    eligible = (|cand) && ((in_service_q == '0) || (top > is_top));
    for (int i = 0; i < NUM_SRC; i++) begin
      id_onehot[i] = (irq_id_q == ID_BITS'(i));
      is_onehot[i] = (is_top == ID_BITS'(i));
    end
    ack_fire = (state_q == REQ) && irq_ack;
    // Ack takes precedence over a withdraw caused by the source being masked.
    withdraw = (state_q == REQ) && !irq_ack && !(|(enable_q & id_onehot));
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: if (eligible) begin
        irq_id_d = top;
        state_d  = REQ;
      end
      REQ: if (ack_fire || withdraw) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (ack_fire) pending_d = pending_d & ~id_onehot;
    pending_d = pending_d | edge_det;

    // eret retires the innermost level before an ack in the same cycle adds a new one.
    in_service_d = in_service_q;
    if (eret && (in_service_q != '0)) in_service_d = in_service_d & ~is_onehot;
    if (ack_fire) in_service_d = in_service_d | id_onehot;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    src_d <= src;
    if (rst) begin
      state_q      <= IDLE;
      irq_id_q     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      if (en_we) enable_q <= en_wdata;
    end
  end

  assign irq        = (state_q == REQ);
  assign irq_id     = irq_id_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign enable     = enable_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed, table-driven bench for irq_priority_ctrl (NUM_SRC=4, ID_BITS=2).
module tb_irq_priority_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] src = '0;
  logic       en_we = 1'b0;
  logic [3:0] en_wdata = '0;
  logic       irq_ack = 1'b0;
  logic       eret = 1'b0;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending, in_service, enable;

  int total = 0;
  int bad   = 0;

  irq_priority_ctrl #(.NUM_SRC(4), .ID_BITS(2)) dut (
    .clk(clk), .rst(rst), .src(src), .en_we(en_we), .en_wdata(en_wdata),
    .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack), .eret(eret),
    .pending(pending), .in_service(in_service), .enable(enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] src;
    logic       we;
    logic [3:0] wd;
    logic       ack;
    logic       eret;
    logic       e_irq;
    logic [1:0] e_id;
    logic [3:0] e_pend;
    logic [3:0] e_is;
    logic [3:0] e_en;
  } vec_t;

  vec_t vecs[36];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then sample just after the edge.
  task automatic apply(input logic r, input logic [3:0] s, input logic we,
                       input logic [3:0] wd, input logic a, input logic e);
    rst = r; src = s; en_we = we; en_wdata = wd; irq_ack = a; eret = e;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic e_irq, input logic [1:0] e_id,
                            input logic [3:0] e_pend, input logic [3:0] e_is,
                            input logic [3:0] e_en);
    check({tag, " irq"}, 32'(irq), 32'(e_irq));
    check({tag, " irq_id"}, 32'(irq_id), 32'(e_id));
    check({tag, " pending"}, 32'(pending), 32'(e_pend));
    check({tag, " in_service"}, 32'(in_service), 32'(e_is));
    check({tag, " enable"}, 32'(enable), 32'(e_en));
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] s, input logic we,
                      input logic [3:0] wd, input logic a, input logic e,
                      input logic e_irq, input logic [1:0] e_id, input logic [3:0] e_pend,
                      input logic [3:0] e_is, input logic [3:0] e_en);
    apply(r, s, we, wd, a, e);
    expect_all(tag, e_irq, e_id, e_pend, e_is, e_en);
  endtask

  initial begin
    //          rst src     we wd      ack eret irq id pend    is      en
    // basic request/ack on source 1
    vecs[0]  = '{1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{0, 4'b0000, 1, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111};
    vecs[2]  = '{0, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b1111};
    vecs[3]  = '{0, 4'b0010, 0, 4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0000, 4'b1111};
    vecs[4]  = '{0, 4'b0010, 0, 4'b0000, 1, 0, 0, 1, 4'b0000, 4'b0010, 4'b1111};
    vecs[5]  = '{0, 4'b0000, 0, 4'b0000, 0, 1, 0, 1, 4'b0000, 4'b0000, 4'b1111};
    // simultaneous rises on 0 and 2
    vecs[6]  = '{0, 4'b0101, 0, 4'b0000, 0, 0, 0, 1, 4'b0101, 4'b0000, 4'b1111};
    vecs[7]  = '{0, 4'b0101, 0, 4'b0000, 0, 0, 1, 2, 4'b0101, 4'b0000, 4'b1111};
    vecs[8]  = '{0, 4'b0101, 0, 4'b0000, 1, 0, 0, 2, 4'b0001, 4'b0100, 4'b1111};
    vecs[9]  = '{0, 4'b0101, 0, 4'b0000, 0, 1, 0, 2, 4'b0001, 4'b0000, 4'b1111};
    vecs[10] = '{0, 4'b0101, 0, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0000, 4'b1111};
    vecs[11] = '{0, 4'b0101, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0001, 4'b1111};
    vecs[12] = '{0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1111};
    // nesting: 1 in service, 3 preempts, 0 waits for both erets
    vecs[13] = '{0, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b1111};
    vecs[14] = '{0, 4'b0010, 0, 4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0000, 4'b1111};
    vecs[15] = '{0, 4'b0010, 0, 4'b0000, 1, 0, 0, 1, 4'b0000, 4'b0010, 4'b1111};
    vecs[16] = '{0, 4'b1010, 0, 4'b0000, 0, 0, 0, 1, 4'b1000, 4'b0010, 4'b1111};
    vecs[17] = '{0, 4'b1010, 0, 4'b0000, 0, 0, 1, 3, 4'b1000, 4'b0010, 4'b1111};
    vecs[18] = '{0, 4'b1010, 0, 4'b0000, 1, 0, 0, 3, 4'b0000, 4'b1010, 4'b1111};
    vecs[19] = '{0, 4'b1011, 0, 4'b0000, 0, 0, 0, 3, 4'b0001, 4'b1010, 4'b1111};
    vecs[20] = '{0, 4'b1011, 0, 4'b0000, 0, 0, 0, 3, 4'b0001, 4'b1010, 4'b1111};
    vecs[21] = '{0, 4'b1011, 0, 4'b0000, 0, 1, 0, 3, 4'b0001, 4'b0010, 4'b1111};
    vecs[22] = '{0, 4'b1011, 0, 4'b0000, 0, 0, 0, 3, 4'b0001, 4'b0010, 4'b1111};
    vecs[23] = '{0, 4'b1011, 0, 4'b0000, 0, 1, 0, 3, 4'b0001, 4'b0000, 4'b1111};
    vecs[24] = '{0, 4'b1011, 0, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0000, 4'b1111};
    vecs[25] = '{0, 4'b1011, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0001, 4'b1111};
    vecs[26] = '{0, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1111};
    // masking holds pending until re-enabled
    vecs[27] = '{0, 4'b0000, 1, 4'b1011, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1011};
    vecs[28] = '{0, 4'b0100, 0, 4'b0000, 0, 0, 0, 0, 4'b0100, 4'b0000, 4'b1011};
    vecs[29] = '{0, 4'b0100, 0, 4'b0000, 0, 0, 0, 0, 4'b0100, 4'b0000, 4'b1011};
    vecs[30] = '{0, 4'b0100, 0, 4'b0000, 0, 0, 0, 0, 4'b0100, 4'b0000, 4'b1011};
    vecs[31] = '{0, 4'b0100, 1, 4'b1111, 0, 0, 0, 0, 4'b0100, 4'b0000, 4'b1111};
    vecs[32] = '{0, 4'b0100, 0, 4'b0000, 0, 0, 1, 2, 4'b0100, 4'b0000, 4'b1111};
    vecs[33] = '{0, 4'b0100, 0, 4'b0000, 1, 0, 0, 2, 4'b0000, 4'b0100, 4'b1111};
    vecs[34] = '{0, 4'b0000, 0, 4'b0000, 0, 1, 0, 2, 4'b0000, 4'b0000, 4'b1111};
    // ack in IDLE and eret with nothing in service are both ignored
    vecs[35] = '{0, 4'b0000, 0, 4'b0000, 1, 1, 0, 2, 4'b0000, 4'b0000, 4'b1111};

    @(posedge clk);
    #1;
    for (int i = 0; i < 36; i++) begin
      step($sformatf("v%0d", i), vecs[i].rst, vecs[i].src, vecs[i].we, vecs[i].wd,
           vecs[i].ack, vecs[i].eret, vecs[i].e_irq, vecs[i].e_id, vecs[i].e_pend,
           vecs[i].e_is, vecs[i].e_en);
    end

    // irq_id stays stable in REQ, then withdraw and ack-vs-withdraw corners
    step("h1",  0, 4'b0010, 0, 4'b0000, 0, 0, 0, 2, 4'b0010, 4'b0000, 4'b1111);
    step("h2",  0, 4'b0010, 0, 4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0000, 4'b1111);
    step("h3",  0, 4'b1010, 0, 4'b0000, 0, 0, 1, 1, 4'b1010, 4'b0000, 4'b1111);
    step("h4",  0, 4'b1010, 0, 4'b0000, 0, 0, 1, 1, 4'b1010, 4'b0000, 4'b1111);
    step("h5",  0, 4'b1010, 0, 4'b0000, 1, 0, 0, 1, 4'b1000, 4'b0010, 4'b1111);
    step("h6",  0, 4'b1010, 0, 4'b0000, 0, 0, 1, 3, 4'b1000, 4'b0010, 4'b1111);
    step("h7",  0, 4'b1010, 1, 4'b0111, 0, 0, 1, 3, 4'b1000, 4'b0010, 4'b0111);
    step("h8",  0, 4'b1010, 0, 4'b0000, 0, 0, 0, 3, 4'b1000, 4'b0010, 4'b0111);
    step("h9",  0, 4'b1010, 0, 4'b0000, 0, 1, 0, 3, 4'b1000, 4'b0000, 4'b0111);
    step("h10", 0, 4'b1010, 1, 4'b1111, 0, 0, 0, 3, 4'b1000, 4'b0000, 4'b1111);
    step("h11", 0, 4'b1010, 0, 4'b0000, 0, 0, 1, 3, 4'b1000, 4'b0000, 4'b1111);
    step("h12", 0, 4'b1010, 1, 4'b0111, 1, 0, 0, 3, 4'b0000, 4'b1000, 4'b0111);
    step("h13", 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 3, 4'b0000, 4'b0000, 4'b0111);
    step("h14", 0, 4'b0000, 1, 4'b1111, 0, 0, 0, 3, 4'b0000, 4'b0000, 4'b1111);
    step("h15", 0, 4'b1000, 0, 4'b0000, 0, 0, 0, 3, 4'b1000, 4'b0000, 4'b1111);
    step("h16", 0, 4'b1000, 0, 4'b0000, 0, 0, 1, 3, 4'b1000, 4'b0000, 4'b1111);
    step("h17", 0, 4'b1000, 1, 4'b0111, 0, 0, 1, 3, 4'b1000, 4'b0000, 4'b0111);
    step("h18", 0, 4'b1000, 0, 4'b0000, 1, 0, 0, 3, 4'b0000, 4'b1000, 4'b0111);
    step("h19", 0, 4'b0000, 1, 4'b1111, 0, 1, 0, 3, 4'b0000, 4'b0000, 4'b1111);

    // reset with lines held high, then reset in the middle of a handshake
    step("r1", 1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    step("r2", 0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    step("r3", 0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    step("r4", 0, 4'b1111, 1, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111);
    step("r5", 0, 4'b1110, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111);
    step("r6", 0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b1111);
    step("r7", 0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0000, 4'b1111);
    step("r8", 1, 4'b1111, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
